// File: rtl/seg_digit_scanner_if.sv
// Bus between the display scanner and its controller: load strobe and value in,
// per-slot digit code, anode enables and status out.
interface seg_digit_scanner_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [3:0]            digit;
  logic [DIGITS-1:0]     an;
  logic                  pending;
  logic                  frame_tick;

  modport master (
    output load, value,
    input  digit, an, pending, frame_tick
  );

  modport slave (
    input  load, value,
    output digit, an, pending, frame_tick
  );
endinterface

// File: rtl/seg_digit_scanner.sv
// Time-multiplexing scanner for a multi-digit 7-segment display: selects one BCD
// nibble per refresh slot, drives its active-low anode after a dead time, blanks
// leading zeros and swaps in new values only at frame boundaries.
module seg_digit_scanner #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned REFRESH_DIV   = 8,
  parameter int unsigned DEAD          = 2,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_digit_scanner_if.slave  bus
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [3:0]       BLANK    = 4'hF;

  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [W-1:0]      shadow, shadow_nxt;
  logic [W-1:0]      active, active_nxt;
  logic              pending_q, pending_nxt;
  logic              tick_q, tick_nxt;
  logic [3:0]        digit_q, digit_nxt;
  logic [DIGITS-1:0] an_q, an_nxt;

  logic              in_dead_c;
  logic              div_wrap_c;
  logic              frame_c;
  logic [DIGITS:0]   zero_above_c;
  logic [3:0]        sel_c;
  logic              sel_blank_c;

  // Dead-time window at the start of every slot; empty when DEAD is 0
  generate
    if (DEAD == 0) begin : g_no_dead
      assign in_dead_c = 1'b0;
    end else begin : g_dead
      assign in_dead_c = (div_cnt < DIV_W'(DEAD));
    end
  endgenerate

  // Next-state, digit selection, blanking and anode decode
  always_comb begin
    div_nxt      = div_cnt;
    idx_nxt      = idx;
    shadow_nxt   = shadow;
    active_nxt   = active;
    pending_nxt  = pending_q;
    tick_nxt     = 1'b0;
    digit_nxt    = BLANK;
    an_nxt       = '1;
    sel_c        = 4'h0;
    sel_blank_c  = 1'b0;
    zero_above_c = '0;

    div_wrap_c = (div_cnt == DIV_LAST);
    frame_c    = div_wrap_c && (idx == IDX_LAST);

    if (div_wrap_c) begin
      div_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      div_nxt = div_cnt + DIV_W'(1);
    end

    // Double buffer: a coincident load bypasses the shadow so it is never lost
    if (bus.load && frame_c) begin
      active_nxt  = bus.value;
      shadow_nxt  = bus.value;
      pending_nxt = 1'b0;
    end else if (bus.load) begin
      shadow_nxt  = bus.value;
      pending_nxt = 1'b1;
    end else if (frame_c && pending_q) begin
      active_nxt  = shadow;
      pending_nxt = 1'b0;
    end
    tick_nxt = frame_c;

    // zero_above_c[k]: nibbles DIGITS-1 down to k of active are all zero
    zero_above_c[DIGITS] = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above_c[k] = zero_above_c[k+1] && (active[4*k +: 4] == 4'h0);
    end

    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_c       = active[4*k +: 4];
        sel_blank_c = (BLANK_LEADING != 0) && (k > 0) && zero_above_c[k];
      end
    end

    digit_nxt = sel_blank_c ? BLANK : sel_c;
    an_nxt    = in_dead_c ? '1 : ~(DIGITS'(1) << idx);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      idx       <= '0;
      shadow    <= '0;
      active    <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      digit_q   <= BLANK;
      an_q      <= '1;
    end else begin
      div_cnt   <= div_nxt;
      idx       <= idx_nxt;
      shadow    <= shadow_nxt;
      active    <= active_nxt;
      pending_q <= pending_nxt;
      tick_q    <= tick_nxt;
      digit_q   <= digit_nxt;
      an_q      <= an_nxt;
    end
  end

  assign bus.digit      = digit_q;
  assign bus.an         = an_q;
  assign bus.pending    = pending_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Bench for seg_digit_scanner: two instances (leading-zero blanking on and off)
// share stimulus; expected per-slot digit/anode pairs are queued at load time
// and popped as each display slot is sampled.
module tb_seg_digit_scanner;

  typedef struct packed {
    logic [3:0] dig;
    logic [3:0] an;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  exp_t nb_q[$];

  seg_digit_scanner_if #(.DIGITS(4)) bus ();
  seg_digit_scanner_if #(.DIGITS(4)) bus_nb ();

  assign bus_nb.load  = bus.load;
  assign bus_nb.value = bus.value;

  seg_digit_scanner #(
    .DIGITS(4), .REFRESH_DIV(8), .DEAD(2), .BLANK_LEADING(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seg_digit_scanner #(
    .DIGITS(4), .REFRESH_DIV(8), .DEAD(2), .BLANK_LEADING(0)
  ) dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue one frame of expectations; nibble k is the digit expected in slot k
  task automatic push_frame(input logic [15:0] main_dig, input logic [15:0] nb_dig);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.an  = ~(4'b0001 << k);
      e.dig = main_dig[4*k +: 4];
      exp_q.push_back(e);
      e.dig = nb_dig[4*k +: 4];
      nb_q.push_back(e);
    end
  endtask

  // Called at the negedge where slot 0 has just begun internally
  task automatic check_slots(input string tag);
    exp_t e;
    exp_t n;
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 5 : 8) @(negedge clk);
      checks++;
      if (exp_q.size() == 0 || nb_q.size() == 0) begin
        errors++;
        $display("FAIL %s slot %0d: scoreboard empty", tag, k);
      end else begin
        e = exp_q.pop_front();
        n = nb_q.pop_front();
        if (bus.digit !== e.dig || bus.an !== e.an) begin
          errors++;
          $display("FAIL %s slot %0d: digit=%h an=%b expected digit=%h an=%b",
                   tag, k, bus.digit, bus.an, e.dig, e.an);
        end
        checks++;
        if (bus_nb.digit !== n.dig || bus_nb.an !== n.an) begin
          errors++;
          $display("FAIL %s_noblank slot %0d: digit=%h an=%b expected digit=%h an=%b",
                   tag, k, bus_nb.digit, bus_nb.an, n.dig, n.an);
        end
      end
    end
  endtask

  // Bounded wait for frame_tick, sampled on negedges
  task automatic wait_frame(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: frame_tick not seen within 100 cycles", tag);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bus.load  = 1'b1;
    bus.value = v;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  task automatic check_pending(input string tag, input logic expv);
    checks++;
    if (bus.pending !== expv) begin
      errors++;
      $display("FAIL %s: pending=%b expected %b", tag, bus.pending, expv);
    end
  endtask

  task automatic test_reset;
    logic [3:0] an_e;
    logic [3:0] dig_e;
    logic       tick_e;
    int         slot;
    int         pos;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.an !== 4'hF || bus.digit !== 4'hF || bus.pending !== 1'b0 || bus.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: an=%b digit=%h pending=%b tick=%b expected 1111 f 0 0",
               bus.an, bus.digit, bus.pending, bus.frame_tick);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      pos    = (c - 1) % 8;
      slot   = (c - 1) / 8;
      an_e   = (pos < 2) ? 4'hF : ~(4'b0001 << slot);
      dig_e  = (slot == 0) ? 4'h0 : 4'hF;
      tick_e = (c == 32);
      checks++;
      if (bus.an !== an_e || bus.digit !== dig_e || bus.frame_tick !== tick_e) begin
        errors++;
        $display("FAIL idle cycle %0d: an=%b digit=%h tick=%b expected an=%b digit=%h tick=%b",
                 c, bus.an, bus.digit, bus.frame_tick, an_e, dig_e, tick_e);
      end
      checks++;
      if (bus_nb.digit !== 4'h0 || bus_nb.an !== an_e) begin
        errors++;
        $display("FAIL idle_noblank cycle %0d: digit=%h an=%b expected digit=0 an=%b",
                 c, bus_nb.digit, bus_nb.an, an_e);
      end
    end
  endtask

  task automatic test_full_scan;
    repeat (10) @(negedge clk);
    pulse_load(16'h1234);
    check_pending("full_scan_pending_set", 1'b1);
    push_frame(16'h1234, 16'h1234);
    wait_frame("full_scan");
    check_pending("full_scan_pending_clear", 1'b0);
    check_slots("full_scan");
  endtask

  task automatic test_leading_zeros;
    repeat (6) @(negedge clk);
    pulse_load(16'h0050);
    check_pending("lz_pending_set", 1'b1);
    push_frame(16'hFF50, 16'h0050);
    wait_frame("leading_zeros");
    check_slots("leading_zeros");
  endtask

  task automatic test_overwrite;
    repeat (6) @(negedge clk);
    pulse_load(16'h1111);
    repeat (4) @(negedge clk);
    pulse_load(16'h2222);
    check_pending("overwrite_pending", 1'b1);
    push_frame(16'h2222, 16'h2222);
    wait_frame("overwrite");
    check_slots("overwrite");
  endtask

  task automatic test_coincident_load;
    wait_frame("coincident_align");
    repeat (31) @(negedge clk);
    pulse_load(16'h9876);
    checks++;
    if (bus.frame_tick !== 1'b1 || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL coincident_boundary: tick=%b pending=%b expected tick=1 pending=0",
               bus.frame_tick, bus.pending);
    end
    push_frame(16'h9876, 16'h9876);
    check_slots("coincident");
  endtask

  task automatic test_async_reset;
    wait_frame("async_align");
    repeat (20) @(negedge clk);
    pulse_load(16'h4321);
    check_pending("async_pending_before", 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.an !== 4'hF || bus.digit !== 4'hF || bus.pending !== 1'b0 || bus.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: an=%b digit=%h pending=%b tick=%b expected 1111 f 0 0",
               bus.an, bus.digit, bus.pending, bus.frame_tick);
    end
    checks++;
    if (bus_nb.an !== 4'hF || bus_nb.digit !== 4'hF) begin
      errors++;
      $display("FAIL async_reset_noblank: an=%b digit=%h expected 1111 f",
               bus_nb.an, bus_nb.digit);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame(16'hFFF0, 16'h0000);
    push_frame(16'hFFF0, 16'h0000);
    check_slots("after_reset");
    check_pending("after_reset_pending", 1'b0);
    wait_frame("after_reset");
    check_slots("after_reset_frame2");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.load  = 1'b0;
    bus.value = 16'h0000;
    test_reset();
    test_full_scan();
    test_leading_zeros();
    test_overwrite();
    test_coincident_load();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
